// File: rtl/disp_demux_capture_if.sv
// Multiplexed 7-segment display bus as seen by the capture block:
// anode strobes and segment bus in, reconstructed digits and status out.
interface disp_demux_capture_if;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [6:0] dig0;
  logic [6:0] dig1;
  logic [6:0] dig2;
  logic [6:0] dig3;
  logic [3:0] dig_valid;
  logic       frame_done;
  logic       seq_err;
  logic       stale;

  modport master (
    output an, sseg,
    input  dig0, dig1, dig2, dig3, dig_valid, frame_done, seq_err, stale
  );

  modport slave (
    input  an, sseg,
    output dig0, dig1, dig2, dig3, dig_valid, frame_done, seq_err, stale
  );
endinterface

// File: rtl/disp_demux_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus: synchronizes, deglitches and
// demultiplexes the strobed segment codes, and checks the 0-1-2-3 scan order.
module disp_demux_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  disp_demux_capture_if.slave   bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]     STAB_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;
  localparam logic [TIMEOUT_W-1:0] WD_PRE   = WD_MAX - 1'b1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
  } pins_t;

  localparam pins_t PINS_IDLE = '{an: 4'hF, sseg: 7'h7F};

  pins_t                r_sync1;
  pins_t                r_sync2;
  logic [CNT_W-1:0]     r_stab_cnt;
  logic                 r_armed;

  logic [6:0]           r_dig [4];
  logic [3:0]           r_valid;
  logic [1:0]           r_last_idx;
  logic                 r_last_vld;
  logic [1:0]           r_prog;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_stale;
  logic                 r_frame_done;
  logic                 r_seq_err;

  logic                 w_changed;
  logic                 w_stable;
  logic                 w_capture;
  logic                 w_illegal;
  logic [1:0]           w_idx;
  logic                 w_out_of_order;
  logic [1:0]           w_prog_nxt;
  logic                 w_frame;

  // r_sync2 is the synchronized bus; a window is complete once it has matched
  // its predecessor for STABLE_CYCLES-1 consecutive edges since the last change.
  assign w_changed = (r_sync1 != r_sync2);
  assign w_stable  = r_armed && (r_stab_cnt == STAB_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= PINS_IDLE;
      r_sync2    <= PINS_IDLE;
      r_stab_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sync1 <= {bus.an, bus.sseg};
      r_sync2 <= r_sync1;
      if (w_changed) begin
        r_stab_cnt <= '0;
        r_armed    <= 1'b1;
      end else begin
        if (r_stab_cnt != STAB_MAX) r_stab_cnt <= r_stab_cnt + 1'b1;
        if (w_stable) r_armed <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_capture = 1'b0;
    w_illegal = 1'b0;
    w_idx     = 2'd0;
    if (w_stable) begin
      case (r_sync2.an)
        4'b1110: begin w_capture = 1'b1; w_idx = 2'd0; end
        4'b1101: begin w_capture = 1'b1; w_idx = 2'd1; end
        4'b1011: begin w_capture = 1'b1; w_idx = 2'd2; end
        4'b0111: begin w_capture = 1'b1; w_idx = 2'd3; end
        4'b1111: ;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // Staying on the same digit is a legal recapture; the 2-bit add wraps 3 -> 0.
  assign w_out_of_order = w_capture && r_last_vld &&
                          (w_idx != r_last_idx) && (w_idx != r_last_idx + 2'd1);

  always_comb begin
    w_prog_nxt = r_prog;
    w_frame    = 1'b0;
    if (w_capture) begin
      if (w_idx == 2'd0) begin
        w_prog_nxt = 2'd1;
      end else if (w_out_of_order) begin
        w_prog_nxt = 2'd0;
      end else if (w_idx == 2'd3 && r_prog == 2'd3) begin
        w_frame    = 1'b1;
        w_prog_nxt = 2'd0;
      end else if (w_idx == r_prog) begin
        w_prog_nxt = r_prog + 2'd1;
      end
    end
  end

  // NOTE: the four digit registers are reset to blank because they are visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_dig[i] <= 7'h7F;
      r_valid      <= '0;
      r_last_idx   <= 2'd0;
      r_last_vld   <= 1'b0;
      r_prog       <= 2'd0;
      r_wd         <= '0;
      r_stale      <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_frame_done <= w_frame;
      r_seq_err    <= w_illegal | w_out_of_order;
      r_prog       <= w_prog_nxt;
      if (w_capture) begin
        r_dig[w_idx]   <= r_sync2.sseg;
        r_valid[w_idx] <= 1'b1;
        r_last_idx     <= w_idx;
        r_last_vld     <= 1'b1;
        r_wd           <= '0;
        r_stale        <= 1'b0;
      end else if (r_wd != WD_MAX) begin
        r_wd <= r_wd + 1'b1;
        if (r_wd == WD_PRE) begin
          r_stale <= 1'b1;
          r_valid <= '0;
        end
      end
    end
  end

  assign bus.dig0       = r_dig[0];
  assign bus.dig1       = r_dig[1];
  assign bus.dig2       = r_dig[2];
  assign bus.dig3       = r_dig[3];
  assign bus.dig_valid  = r_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.seq_err    = r_seq_err;
  assign bus.stale      = r_stale;

endmodule

// File: tb/tb_disp_demux_capture.sv
// Bench for disp_demux_capture: table of display slots with hand-derived results,
// directed multi-cycle corner cases, and random scans checked against a history-based model.
module tb_disp_demux_capture;

  localparam int S     = 4;
  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;
  localparam int HIST  = S + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  disp_demux_capture_if bus ();

  disp_demux_capture #(.STABLE_CYCLES(S), .TIMEOUT_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from the history of sampled pin values: a window fires when the bus value
  // that reached the synchronizer output has been seen S edges in a row, after a change.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
  } pin_t;

  pin_t       hist [HIST];
  logic [6:0] m_dig [4];
  logic [3:0] m_valid;
  logic       m_frame, m_seq, m_stale;
  int         m_last, m_prog, m_idle;

  task automatic model_reset();
    for (int j = 0; j < HIST; j++) hist[j] = {4'hF, 7'h7F};
    for (int k = 0; k < 4; k++) m_dig[k] = 7'h7F;
    m_valid = 4'h0;
    m_frame = 1'b0;
    m_seq   = 1'b0;
    m_stale = 1'b0;
    m_last  = -1;
    m_prog  = 0;
    m_idle  = 0;
  endtask

  task automatic model_step();
    pin_t w;
    bit   win, cap, err;
    int   idx;
    for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = {bus.an, bus.sseg};
    win = (hist[S+2] != hist[2]);
    for (int j = 3; j <= S + 1; j++) if (hist[j] != hist[2]) win = 0;
    m_frame = 1'b0;
    m_seq   = 1'b0;
    cap     = 0;
    idx     = 0;
    if (win) begin
      w = hist[2];
      if (w.an != 4'hF) begin
        if ($countones(~w.an) == 1) begin
          for (int k = 0; k < 4; k++) if (!w.an[k]) idx = k;
          cap = 1;
          m_dig[idx]   = w.sseg;
          m_valid[idx] = 1'b1;
          err = (m_last >= 0) && (idx != m_last) && (idx != (m_last + 1) % 4);
          if (err) m_seq = 1'b1;
          if (idx == 0) m_prog = 1;
          else if (err) m_prog = 0;
          else if (idx == 3 && m_prog == 3) begin m_frame = 1'b1; m_prog = 0; end
          else if (idx == m_prog) m_prog++;
          m_last = idx;
        end else begin
          m_seq = 1'b1;
        end
      end
    end
    if (cap) begin
      m_idle  = 0;
      m_stale = 1'b0;
    end else if (m_idle < LIMIT) begin
      m_idle++;
      if (m_idle == LIMIT) begin
        m_stale = 1'b1;
        m_valid = 4'h0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- drivers ----------------
  function automatic logic [6:0] dut_dig(input int i);
    case (i)
      0:       return bus.dig0;
      1:       return bus.dig1;
      2:       return bus.dig2;
      default: return bus.dig3;
    endcase
  endfunction

  task automatic compare_model();
    check("dig0", bus.dig0, m_dig[0]);
    check("dig1", bus.dig1, m_dig[1]);
    check("dig2", bus.dig2, m_dig[2]);
    check("dig3", bus.dig3, m_dig[3]);
    check("dig_valid", bus.dig_valid, m_valid);
    check("frame_done", bus.frame_done, m_frame);
    check("seq_err", bus.seq_err, m_seq);
    check("stale", bus.stale, m_stale);
  endtask

  // Pins change on the falling edge, the DUT samples on the rising edge, outputs are read on the next falling edge.
  task automatic cycle(input logic [3:0] an, input logic [6:0] sseg);
    bus.an   = an;
    bus.sseg = sseg;
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic slot(input logic [3:0] an, input logic [6:0] sseg, input int n);
    for (int c = 0; c < n; c++) cycle(an, sseg);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " dig0"}, bus.dig0, 7'h7F);
    check({tag, " dig1"}, bus.dig1, 7'h7F);
    check({tag, " dig2"}, bus.dig2, 7'h7F);
    check({tag, " dig3"}, bus.dig3, 7'h7F);
    check({tag, " valid"}, bus.dig_valid, 4'h0);
    check({tag, " frame_done"}, bus.frame_done, 1'b0);
    check({tag, " seq_err"}, bus.seq_err, 1'b0);
    check({tag, " stale"}, bus.stale, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.an   = 4'hF;
    bus.sseg = 7'h7F;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset");
  endtask

  // ---------------- slot table ----------------
  typedef struct {
    logic [3:0] an;
    logic [6:0] sseg;
    int         cycles;
    int         n_frame;
    int         n_seq;
    logic [3:0] valid;
    int         chk_idx;
  } row_t;

  localparam int N_ROWS = 20;
  row_t rows [N_ROWS];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nf, ns, n, cur;
    logic [3:0] an;

    rows[0]  = '{4'hE, 7'h40,  8, 0, 0, 4'h1,  0};
    rows[1]  = '{4'hD, 7'h79,  8, 0, 0, 4'h3,  1};
    rows[2]  = '{4'hB, 7'h24,  8, 0, 0, 4'h7,  2};
    rows[3]  = '{4'h7, 7'h30,  8, 1, 0, 4'hF,  3};
    rows[4]  = '{4'hE, 7'h40,  8, 0, 0, 4'hF,  0};
    rows[5]  = '{4'hD, 7'h79,  8, 0, 0, 4'hF,  1};
    rows[6]  = '{4'hD, 7'h00,  3, 0, 0, 4'hF, -1};
    rows[7]  = '{4'hD, 7'h79,  8, 0, 0, 4'hF,  1};
    rows[8]  = '{4'hB, 7'h24,  8, 0, 0, 4'hF,  2};
    rows[9]  = '{4'h7, 7'h30,  8, 1, 0, 4'hF,  3};
    rows[10] = '{4'hE, 7'h11,  8, 0, 0, 4'hF,  0};
    rows[11] = '{4'hD, 7'h22,  8, 0, 0, 4'hF,  1};
    rows[12] = '{4'h7, 7'h33,  8, 0, 1, 4'hF,  3};
    rows[13] = '{4'hE, 7'h11,  8, 0, 0, 4'hF,  0};
    rows[14] = '{4'hD, 7'h22,  8, 0, 0, 4'hF,  1};
    rows[15] = '{4'hB, 7'h44,  8, 0, 0, 4'hF,  2};
    rows[16] = '{4'h7, 7'h33,  8, 1, 0, 4'hF,  3};
    rows[17] = '{4'hC, 7'h55, 10, 0, 1, 4'hF, -1};
    rows[18] = '{4'hF, 7'h7F, 10, 0, 0, 4'h0, -1};
    rows[19] = '{4'hE, 7'h40,  8, 0, 0, 4'h1,  0};

    bus.an   = 4'hF;
    bus.sseg = 7'h7F;
    do_reset();

    for (int r = 0; r < N_ROWS; r++) begin
      nf = 0;
      ns = 0;
      for (int c = 0; c < rows[r].cycles; c++) begin
        cycle(rows[r].an, rows[r].sseg);
        nf += int'(bus.frame_done);
        ns += int'(bus.seq_err);
      end
      check($sformatf("row%0d frame_done pulses", r), nf, rows[r].n_frame);
      check($sformatf("row%0d seq_err pulses", r), ns, rows[r].n_seq);
      check($sformatf("row%0d dig_valid", r), bus.dig_valid, rows[r].valid);
      if (rows[r].chk_idx >= 0)
        check($sformatf("row%0d dig%0d", r, rows[r].chk_idx), dut_dig(rows[r].chk_idx), rows[r].sseg);
    end

    // Four-cycle glitch is long enough to be captured, then the restored code is recaptured.
    do_reset();
    slot(4'hE, 7'h40, 8);
    slot(4'hD, 7'h79, 8);
    ns = 0;
    for (int c = 0; c < 4; c++) begin cycle(4'hD, 7'h00); ns += int'(bus.seq_err); end
    for (int c = 0; c < 2; c++) begin cycle(4'hD, 7'h79); ns += int'(bus.seq_err); end
    check("glitch4 dig1 captured", bus.dig1, 7'h00);
    for (int c = 0; c < 6; c++) begin cycle(4'hD, 7'h79); ns += int'(bus.seq_err); end
    check("glitch4 dig1 restored", bus.dig1, 7'h79);
    check("glitch4 no seq_err", ns, 0);

    // Watchdog: stale exactly LIMIT cycles after the last capture.
    do_reset();
    slot(4'hE, 7'h5A, 6);
    check("stale capture dig0", bus.dig0, 7'h5A);
    n = 0;
    while (!bus.stale && n < 40) begin
      cycle(4'hF, 7'h7F);
      n++;
    end
    check("stale latency", n, LIMIT);
    check("stale clears valid", bus.dig_valid, 4'h0);
    check("stale keeps dig0", bus.dig0, 7'h5A);
    slot(4'hD, 7'h12, 6);
    check("stale cleared by capture", bus.stale, 1'b0);
    check("valid after stale", bus.dig_valid, 4'h2);

    // frame_done latency from the start of the digit-3 slot.
    do_reset();
    slot(4'hE, 7'h40, 8);
    slot(4'hD, 7'h79, 8);
    slot(4'hB, 7'h24, 8);
    n = 0;
    while (!bus.frame_done && n < 20) begin
      cycle(4'h7, 7'h30);
      n++;
    end
    check("frame_done latency", n, 6);

    // Asynchronous reset in the middle of the digit-2 slot.
    do_reset();
    slot(4'hE, 7'h40, 8);
    slot(4'hD, 7'h79, 8);
    slot(4'hB, 7'h24, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nf = 0;
    for (int c = 0; c < 8; c++) begin cycle(4'hB, 7'h24); nf += int'(bus.frame_done); end
    for (int c = 0; c < 8; c++) begin cycle(4'h7, 7'h30); nf += int'(bus.frame_done); end
    check("partial frame after reset", nf, 0);
    nf = 0;
    slot(4'hE, 7'h40, 8);
    slot(4'hD, 7'h79, 8);
    slot(4'hB, 7'h24, 8);
    for (int c = 0; c < 8; c++) begin cycle(4'h7, 7'h30); nf += int'(bus.frame_done); end
    check("full frame after reset", nf, 1);

    // Random scans: mostly in order, with skips, repeats, blanks, illegal strobes and glitches.
    do_reset();
    cur = 0;
    for (int s = 0; s < 300; s++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        an  = ~(4'b0001 << cur);
        cur = (cur + 1) % 4;
      end else if (r < 75) begin
        an = ~(4'b0001 << $urandom_range(0, 3));
      end else if (r < 85) begin
        an = 4'hF;
      end else begin
        an = 4'($urandom_range(0, 15));
      end
      slot(an, 7'($urandom_range(0, 127)), int'($urandom_range(1, 10)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_demux_capture.md
Name: disp_demux_capture

Overview:
- Receive-side counterpart of the 4-digit 7-segment time-multiplexing driver.
- Samples the shared anode strobes (an, active-low one-cold) and segment bus (sseg), filters switching glitches, and reconstructs the four per-digit segment codes into registers.
- Checks that digits are scanned in driver order 0→1→2→3→0.
- Used as an on-chip loopback checker and as a capture front-end for an external multiplexed display bus.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles {an,sseg} must hold unchanged before capture (≥2).
- TIMEOUT_W, 20: width of the no-capture watchdog counter; stale asserts after 2^TIMEOUT_W−1 cycles without a capture.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- an  in  4  anode strobes, active-low, one-cold selects digit (bit i low = digit i)
- sseg  in  7  segment bus, active-low
- dig0  out  7  last captured code for digit 0
- dig1  out  7  last captured code for digit 1
- dig2  out  7  last captured code for digit 2
- dig3  out  7  last captured code for digit 3
- dig_valid  out  4  bit i = dig i captured since reset / last stale
- frame_done  out  1  one-cycle pulse: complete in-order 0,1,2,3 frame captured
- seq_err  out  1  one-cycle pulse: illegal anode pattern or out-of-order digit
- stale  out  1  no capture for 2^TIMEOUT_W−1 cycles

Behaviour:
- Reset (async assert, sync release):
  - dig0..dig3 = 7'h7F; dig_valid = 0; frame_done = seq_err = stale = 0.
  - Synchronizer flops = {4'hF, 7'h7F}; stab_cnt = 0; last_idx invalid; frame progress = 0; watchdog = 0.
- Synchronizer: 2-flop on all 11 input bits. Value stable at pins from edge E appears at sync output at edge E+2.
- Stability filter:
  - Compare sync output with its previous-cycle copy; if changed, stab_cnt←0 and armed←1.
  - Else stab_cnt increments, saturating at STABLE_CYCLES−1.
  - Window is "stable" when stab_cnt = STABLE_CYCLES−1 and armed = 1. Process once, then armed←0 until the next change.
  - A window is stable at edge E+2+STABLE_CYCLES−1; any resulting register write occurs at E+2+STABLE_CYCLES.
  - A value held < STABLE_CYCLES synchronized cycles is ignored entirely.
- Stable-window decode:
  - an = 4'hF (blank): no capture, no error, watchdog keeps counting.
  - an ∈ {1110,1101,1011,0111}: idx = position of the low bit; dig[idx]←sseg, dig_valid[idx]←1, watchdog←0, stale←0.
  - Any other an (≥2 low bits): seq_err pulse, no capture, sequence state unchanged.
- Sequence check, on each capture:
  - If last_idx is valid and idx ∉ {last_idx, (last_idx+1) mod 4}: seq_err pulse, frame progress←0.
  - idx = last_idx (segment change within a slot) is legal: recapture, no progress change.
  - last_idx←idx in all cases.
- Frame tracking:
  - progress counts in-order captures starting at idx 0.
  - Capture of idx 0 always sets progress = 1.
  - idx = progress advances it.
  - Capture of idx 3 with progress = 3 pulses frame_done and sets progress = 0.
  - First capture after reset with idx≠0: no error, progress stays 0.
- Watchdog: increments every cycle with no capture, saturating at 2^TIMEOUT_W−1. On reaching it: stale←1, dig_valid←0, dig values retained.
- Simultaneous events:
  - Capture and watchdog saturation in the same cycle: capture wins.
  - seq_err and frame_done never pulse in the same cycle.
- Reset mid-window: all state returns to reset values immediately; the partial window is discarded.

Test Plan:
- Drive the driver's sequence with STABLE_CYCLES=4, 8 cycles per slot, codes 40,79,24,30 on digits 0..3.
  - Expect dig0..3 = 7'h40,7'h79,7'h24,7'h30 and dig_valid = 4'hF.
  - Expect frame_done pulse 6 clocks after the digit-3 slot starts at the pins.
  - Expect seq_err = 0.
- Glitch rejection:
  - During the digit-1 slot, force sseg = 7'h00 for 3 cycles, then restore 7'h79 → dig1 stays 7'h79, no extra event.
  - Same force held for 4 cycles → dig1 = 7'h00 (recapture, no seq_err).
- Out-of-order scan: slots in order 0,1,3 → seq_err single pulse on the digit-3 capture; dig3 still updated; no frame_done until a new 0,1,2,3.
- Illegal/blank strobes:
  - an = 4'b1100 held 10 cycles → one seq_err pulse, digits unchanged.
  - an = 4'hF held 10 cycles → no pulse, no capture.
- Stale: TIMEOUT_W=4, stop strobing (an = 4'hF) → stale = 1 and dig_valid = 0 exactly 15 cycles after the last capture; the next valid slot clears stale.
- Async reset mid-frame: assert rst_n low between clock edges during the digit-2 slot → outputs return to reset values without a clock; after release, a full frame is required for frame_done.
